pwm_capture_device: RTL and testbench

Peripheral-bus input-capture device, the receiving counterpart of the PWM output device. Measures period and high time of one external pulse-train input, in prescaled clock ticks. Publishes both values atomically to bus-readable registers and raises an interrupt on each completed capture or on a counter overflow. It sits on the peripheral bus beside the PWM, UART and GPIO devices, and is selected by its 4-bit ID.

---
 rtl/pwm_capture_device_if.sv | 25 ++
 rtl/pwm_capture_device.sv | 188 ++++++++++++++++++
 tb/tb_pwm_capture_device.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_device_if.sv
// Peripheral bus bundle shared by the bus master and the capture device.
// Bus semantics: a cycle is live when peripheralEnable is high and the address ID matches. A write commits at that posedge. Read data is combinational while oe is high and requestOutput is asserted, and reads ~0 otherwise.
interface pwm_capture_device_if;
  logic        peripheralEnable;
  logic        peripheralBus_we;
  logic        peripheralBus_oe;
  logic        peripheralBus_busy;
  logic [15:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataRead;
  logic [31:0] peripheralBus_dataWrite;
  logic        requestOutput;

  modport master (
    output peripheralEnable, peripheralBus_we, peripheralBus_oe,
    output peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
    input  peripheralBus_busy, peripheralBus_dataRead, requestOutput
  );

  modport slave (
    input  peripheralEnable, peripheralBus_we, peripheralBus_oe,
    input  peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
    output peripheralBus_busy, peripheralBus_dataRead, requestOutput
  );
endinterface

// File: rtl/pwm_capture_device.sv
// Input-capture peripheral: measures period and high time of capture_in in prescaled ticks.
// Optional `PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample stability filter after the synchronizer.
module pwm_capture_device #(
  parameter logic [3:0] ID         = 4'h0,
  parameter int         WIDTH      = 16,
  parameter int         SCALE_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_capture_device_if.slave   bus,
  input  logic                  capture_in,
  output logic                  capture_irq,
  output logic [1:0]            fsm_state
);

  localparam int CFG_BITS = SCALE_BITS + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [WIDTH-1:0]    counter_q, counter_d, pending_q, pending_d;
  logic [WIDTH-1:0]    period_q, period_d, high_q, high_d, counter_inc;
  logic [31:0]         pre_q, pre_d, pre_mask;
  logic [1:0]          state_q, state_d;
  logic                cap_q, ovf_q, cap_set, ovf_set;
  logic                s1, s2, level, level_q, rise_q, fall_q, tick, ovf_hit;

  wire                  cfg_enable = cfg_q[0];
  wire [SCALE_BITS-1:0] cfg_scale  = cfg_q[SCALE_BITS:1];
  wire                  cfg_cap_ie = cfg_q[SCALE_BITS+1];
  wire                  cfg_ovf_ie = cfg_q[SCALE_BITS+2];

  // Bus decode
  wire [11:0] local_addr = bus.peripheralBus_address[11:0];
  wire id_match = bus.peripheralEnable && (bus.peripheralBus_address[15:12] == ID);
  wire mapped   = (local_addr == 12'h000) || (local_addr == 12'h004) ||
                  (local_addr == 12'h008) || (local_addr == 12'h00C);
  wire wr_hit   = id_match && bus.peripheralBus_we;
  wire cfg_wr   = wr_hit && (local_addr == 12'h000);
  wire st_wr    = wr_hit && (local_addr == 12'h00C) && bus.peripheralBus_byteSelect[0];
  wire clr_cap  = st_wr && bus.peripheralBus_dataWrite[0];
  wire clr_ovf  = st_wr && bus.peripheralBus_dataWrite[1];

  logic unused_bits;
  assign unused_bits = ^{1'b0, bus.peripheralBus_dataWrite, bus.peripheralBus_byteSelect};

  always_comb begin
    cfg_d = cfg_q;
    if (cfg_wr) begin
      for (int i = 0; i < CFG_BITS; i++) begin
        if (bus.peripheralBus_byteSelect[i/8]) cfg_d[i] = bus.peripheralBus_dataWrite[i];
      end
    end
  end

  logic [31:0] rd_data;
  always_comb begin
    rd_data = 32'd0;
    case (local_addr)
      12'h000: rd_data = 32'(cfg_q);
      12'h004: rd_data = 32'(period_q);
      12'h008: rd_data = 32'(high_q);
      12'h00C: rd_data = {29'd0, level, ovf_q, cap_q};
      default: rd_data = 32'd0;
    endcase
  end

  assign bus.requestOutput          = id_match && bus.peripheralBus_oe && mapped;
  assign bus.peripheralBus_dataRead = bus.requestOutput ? rd_data : '1;
  assign bus.peripheralBus_busy     = 1'b0;

  // Input conditioning: synchronizer, optional stability filter, edge pulses
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic h1, h2, filt_q;
  assign level = ((s2 == h1) && (h1 == h2)) ? s2 : filt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      h1 <= 1'b0; h2 <= 1'b0; filt_q <= 1'b0;
    end else begin
      h1 <= s2; h2 <= h1; filt_q <= level;
    end
  end
`else
  assign level = s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; level_q <= 1'b0; rise_q <= 1'b0; fall_q <= 1'b0;
    end else begin
      s1      <= capture_in;
      s2      <= s1;
      level_q <= level;
      rise_q  <= level & ~level_q;
      fall_q  <= ~level & level_q;
    end
  end

  // Prescaler restarts on each rise so ticks are phase-aligned to the measured edge
  assign pre_mask = (32'd1 << cfg_scale) - 32'd1;
  assign tick     = (pre_q == pre_mask);
  always_comb begin
    if (state_q == S_IDLE || rise_q) pre_d = 32'd0;
    else if (pre_q >= pre_mask)      pre_d = 32'd0;
    else                             pre_d = pre_q + 32'd1;
  end

  assign counter_inc = counter_q + WIDTH'(tick);
  assign ovf_hit     = (&counter_q) && tick;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    pending_d = pending_q;
    period_d  = period_q;
    high_d    = high_q;
    cap_set   = 1'b0;
    ovf_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        counter_d = '0;
        if (cfg_enable) state_d = S_ARM;
      end
      S_ARM: begin
        counter_d = '0;
        if (rise_q) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (ovf_hit) begin
          ovf_set = 1'b1; counter_d = '0; state_d = S_ARM;
        end else begin
          counter_d = counter_inc;
          if (fall_q) begin
            pending_d = counter_inc;
            state_d   = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (ovf_hit) begin
          ovf_set = 1'b1; counter_d = '0; state_d = S_ARM;
        end else if (rise_q) begin
          period_d  = counter_inc;
          high_d    = pending_q;
          cap_set   = 1'b1;
          counter_d = '0;
          state_d   = S_HIGH;
        end else begin
          counter_d = counter_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!cfg_enable) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '0;
      state_q   <= S_IDLE;
      counter_q <= '0;
      pending_q <= '0;
      period_q  <= '0;
      high_q    <= '0;
      pre_q     <= '0;
      cap_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      state_q   <= state_d;
      counter_q <= counter_d;
      pending_q <= pending_d;
      period_q  <= period_d;
      high_q    <= high_d;
      pre_q     <= pre_d;
      // A new event in the same cycle as a software clear keeps the flag set
      cap_q     <= (cap_q & ~clr_cap) | cap_set;
      ovf_q     <= (ovf_q & ~clr_ovf) | ovf_set;
    end
  end

  assign capture_irq = (cap_q & cfg_cap_ie) | (ovf_q & cfg_ovf_ie);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_pwm_capture_device.sv
// Directed bench for pwm_capture_device: bus reads are scoreboarded, status pins checked directly.
module tb_pwm_capture_device;

  localparam logic [3:0] DEV_ID = 4'h5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  logic       clk;
  logic       rst;
  logic       capture_in;
  logic       capture_irq;
  logic [1:0] fsm_state;

  pwm_capture_device_if bus ();

  pwm_capture_device #(.ID(DEV_ID), .WIDTH(8), .SCALE_BITS(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .capture_in  (capture_in),
    .capture_irq (capture_irq),
    .fsm_state   (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk) begin
    if (bus.requestOutput) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got %h required no read response", bus.peripheralBus_dataRead);
      end else begin
        logic [31:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus.peripheralBus_dataRead !== e) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", nm, bus.peripheralBus_dataRead, e);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Driver tasks (all start and end at posedge+1)
  task automatic bus_idle();
    bus.peripheralEnable         = 1'b0;
    bus.peripheralBus_we         = 1'b0;
    bus.peripheralBus_oe         = 1'b0;
    bus.peripheralBus_address    = 16'h0000;
    bus.peripheralBus_byteSelect = 4'h0;
    bus.peripheralBus_dataWrite  = 32'h0;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    bus.peripheralEnable         = 1'b1;
    bus.peripheralBus_we         = 1'b1;
    bus.peripheralBus_address    = {DEV_ID, a};
    bus.peripheralBus_dataWrite  = d;
    bus.peripheralBus_byteSelect = be;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [11:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    bus.peripheralEnable      = 1'b1;
    bus.peripheralBus_oe      = 1'b1;
    bus.peripheralBus_address = {DEV_ID, a};
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_probe(input logic [15:0] full_addr, input string nm);
    @(posedge clk); #1;
    bus.peripheralEnable      = 1'b1;
    bus.peripheralBus_oe      = 1'b1;
    bus.peripheralBus_address = full_addr;
    #1;
    check({nm, "_req"}, {31'd0, bus.requestOutput}, 32'd0);
    check({nm, "_data"}, bus.peripheralBus_dataRead, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_level(input logic v, input int n);
    capture_in = v;
    wait_cycles(n);
  endtask

  // n full pulses, then one more rise (which publishes the last period) and a short low tail
  task automatic train(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      drive_level(1'b1, hi);
      drive_level(1'b0, lo);
    end
    drive_level(1'b1, hi);
    drive_level(1'b0, 10);
  endtask

  initial begin
    bus_idle();
    capture_in = 1'b0;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);

    // Reset state
    check("rst_irq", {31'd0, capture_irq}, 32'd0);
    check("rst_busy", {31'd0, bus.peripheralBus_busy}, 32'd0);
    check("rst_req", {31'd0, bus.requestOutput}, 32'd0);
    check("rst_dataread", bus.peripheralBus_dataRead, 32'hFFFF_FFFF);
    check("rst_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    bus_read(12'h000, 32'h0, "rst_config");
    bus_read(12'h004, 32'h0, "rst_period");
    bus_read(12'h008, 32'h0, "rst_high");
    bus_read(12'h00C, 32'h0, "rst_status");
    bus_probe({DEV_ID, 12'h010}, "unmapped");
    bus_probe({4'h1, 12'h000}, "other_id");

    // Byte lanes, read-only registers, enable timing
    bus_write(12'h000, 32'h0000_0041, 4'b1110);
    bus_read(12'h000, 32'h0, "cfg_lane_masked");
    bus_write(12'h004, 32'hFFFF_FFFF, 4'hF);
    bus_read(12'h004, 32'h0, "period_ro");
    bus_write(12'h000, 32'hFFFF_FF41, 4'b0001);
    check("enable_still_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});
    wait_cycles(1);
    check("enable_arm", {30'd0, fsm_state}, {30'd0, S_ARM});
    bus_read(12'h000, 32'h41, "cfg_readback");

    // 10 high / 30 low at clockScale 0
    train(10, 30, 1);
    bus_read(12'h004, 32'd40, "s0_period");
    bus_read(12'h008, 32'd10, "s0_high");
    bus_read(12'h00C, 32'h1, "s0_status");
    check("s0_irq", {31'd0, capture_irq}, 32'd1);
    bus_write(12'h00C, 32'h1, 4'h1);
    bus_read(12'h00C, 32'h0, "s0_cleared");
    check("s0_irq_cleared", {31'd0, capture_irq}, 32'd0);
    train(10, 30, 1);
    bus_read(12'h00C, 32'h1, "s0_reset_again");
    bus_read(12'h004, 32'd40, "s0_period2");
    check("s0_irq_again", {31'd0, capture_irq}, 32'd1);
    bus_write(12'h000, 32'h0, 4'hF);

    // 20 high / 60 low at clockScale 2
    bus_write(12'h00C, 32'h3, 4'h1);
    bus_write(12'h000, 32'h45, 4'hF);
    train(20, 60, 1);
    bus_read(12'h004, 32'd20, "s2_period");
    bus_read(12'h008, 32'd5, "s2_high");
    bus_read(12'h000, 32'h45, "s2_config");
    bus_write(12'h000, 32'h0, 4'hF);

    // Counter overflow (WIDTH 8)
    bus_write(12'h00C, 32'h3, 4'h1);
    bus_write(12'h000, 32'h81, 4'hF);
    drive_level(1'b1, 10);
    drive_level(1'b0, 300);
    check("ovf_state_arm", {30'd0, fsm_state}, {30'd0, S_ARM});
    check("ovf_irq", {31'd0, capture_irq}, 32'd1);
    bus_read(12'h00C, 32'h2, "ovf_status");
    bus_read(12'h004, 32'd20, "ovf_period_kept");
    bus_read(12'h008, 32'd5, "ovf_high_kept");
    bus_write(12'h00C, 32'h2, 4'h1);
    bus_read(12'h00C, 32'h0, "ovf_cleared");
    check("ovf_irq_cleared", {31'd0, capture_irq}, 32'd0);
    bus_write(12'h000, 32'h0, 4'hF);

    // Disable mid-HIGH, then re-enable with 8/8 pulses
    bus_write(12'h000, 32'h01, 4'hF);
    drive_level(1'b1, 6);
    check("mid_high_state", {30'd0, fsm_state}, {30'd0, S_HIGH});
    bus_write(12'h000, 32'h0, 4'hF);
    wait_cycles(1);
    check("disable_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});
    drive_level(1'b0, 10);
    bus_read(12'h004, 32'd20, "idle_period_kept");
    bus_write(12'h000, 32'h01, 4'hF);
    train(8, 8, 1);
    bus_read(12'h004, 32'd16, "reen_period");
    bus_read(12'h008, 32'd8, "reen_high");
    bus_write(12'h000, 32'h0, 4'hF);

    // 2-cycle glitch in the low phase of a 10/30 signal
    bus_write(12'h00C, 32'h3, 4'h1);
    bus_write(12'h000, 32'h01, 4'hF);
    drive_level(1'b1, 10);
    drive_level(1'b0, 12);
    drive_level(1'b1, 2);
    drive_level(1'b0, 16);
    drive_level(1'b1, 10);
    drive_level(1'b0, 10);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    bus_read(12'h004, 32'd40, "glitch_period");
    bus_read(12'h008, 32'd10, "glitch_high");
`else
    bus_read(12'h004, 32'd18, "glitch_period");
    bus_read(12'h008, 32'd2, "glitch_high");
`endif
    bus_write(12'h000, 32'h0, 4'hF);

    wait_cycles(4);
    while (exp_q.size() != 0) begin
      string nm;
      void'(exp_q.pop_front());
      nm = name_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no read response required one", nm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
